// File: rtl/iir_coeff_loader.sv
// Byte-stream coefficient programmer for the biquad IIR filter: parses framed
// coefficient sets, validates them, then bursts five writes into one section.
module iir_coeff_loader #(
  parameter int NUM_SECTIONS = 2,
  parameter int COEF_WIDTH   = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            coeff_wr_en,
  output logic [$clog2(NUM_SECTIONS)-1:0] section_index,
  output logic [2:0]                      coeff_sel,
  output logic [COEF_WIDTH-1:0]           coeff_value,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [1:0]                      err_code
);

  localparam int SEC_W = $clog2(NUM_SECTIONS);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SECT  = 3'd1;
  localparam logic [2:0] ST_COEF  = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  localparam logic [7:0]       SYNC_BYTE = 8'hA5;
  localparam logic [7:0]       NUM_SEC_B = 8'(NUM_SECTIONS);
  localparam logic [TMO_W-1:0] TMO_LIM   = TMO_W'(TIMEOUT);

  logic [2:0]            r_state;
  logic [SEC_W-1:0]      r_sect;
  logic                  r_bad;
  logic [3:0]            r_cnt;
  logic [7:0]            r_xor;
  logic [TMO_W-1:0]      r_tmo;
  logic [COEF_WIDTH-1:0] r_stage [5];

  logic                  w_xfer;
  logic [2:0]            w_next_sel;
  logic [TMO_W-1:0]      w_tmo_next;

  assign w_xfer     = s_valid && s_ready;
  assign w_next_sel = coeff_sel + 3'd1;
  assign w_tmo_next = r_tmo + TMO_W'(1);

  // NOTE: staging has no reset; it is always fully rewritten by a frame before use.
  always_ff @(posedge clk) begin
    if (r_state == ST_COEF && w_xfer) begin
      if (!r_cnt[0]) r_stage[r_cnt[3:1]][15:8] <= s_data;
      else           r_stage[r_cnt[3:1]][7:0]  <= s_data;
    end
  end

  // NOTE: every state register uses non-blocking assignment so all outputs update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      s_ready       <= 1'b0;
      coeff_wr_en   <= 1'b0;
      section_index <= '0;
      coeff_sel     <= '0;
      coeff_value   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= '0;
      r_sect        <= '0;
      r_bad         <= 1'b0;
      r_cnt         <= '0;
      r_xor         <= '0;
      r_tmo         <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (w_xfer && s_data == SYNC_BYTE) begin
            r_state <= ST_SECT;
            busy    <= 1'b1;
            r_xor   <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
          end
        end

        ST_WRITE: begin
          if (coeff_sel == 3'd4) begin
            coeff_wr_en <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            s_ready     <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            coeff_sel   <= w_next_sel;
            coeff_value <= r_stage[w_next_sel];
          end
        end

        default: begin
          // In-frame states share the inter-byte timeout.
          if (w_xfer) begin
            r_tmo <= '0;
            if (r_state == ST_SECT) begin
              r_sect  <= s_data[SEC_W-1:0];
              r_bad   <= (s_data >= NUM_SEC_B);
              r_xor   <= r_xor ^ s_data;
              r_state <= ST_COEF;
            end else if (r_state == ST_COEF) begin
              r_xor <= r_xor ^ s_data;
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd9) r_state <= ST_CHK;
            end else if (r_bad || s_data != r_xor) begin
              err      <= 1'b1;
              err_code <= r_bad ? 2'd2 : 2'd1;
              busy     <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              s_ready       <= 1'b0;
              coeff_wr_en   <= 1'b1;
              coeff_sel     <= 3'd0;
              coeff_value   <= r_stage[0];
              section_index <= r_sect;
              r_state       <= ST_WRITE;
            end
          end else if (r_tmo == TMO_LIM) begin
            err      <= 1'b1;
            err_code <= 2'd3;
            busy     <= 1'b0;
            s_ready  <= 1'b1;
            r_tmo    <= '0;
            r_state  <= ST_IDLE;
          end else begin
            // Drop ready one cycle early so no byte lands in the timeout cycle.
            r_tmo   <= w_tmo_next;
            s_ready <= (w_tmo_next != TMO_LIM);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Byte-stream coefficient programmer for the biquad IIR filter: the initiator side of the filter's coefficient write port. Receives framed coefficient sets over a valid/ready byte interface, checks framing, section index and checksum, then issues five back-to-back coefficient writes (b0, b1, b2, a1, a2) to one section. Sits between the host or config UART bridge and the filter's `coeff_wr_en/section_index/coeff_sel/coeff_value` inputs.

## Interface
- `NUM_SECTIONS`, 2, number of filter sections; valid section indices are 0..NUM_SECTIONS-1.
- `COEF_WIDTH`, 16, coefficient width; only 16 is supported (two bytes per coefficient).
- `TIMEOUT`, 1024, maximum idle cycles allowed between bytes inside a frame.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `s_data`  in  8  incoming byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader can accept a byte; the byte transfers on an edge where `s_valid && s_ready`.
- `coeff_wr_en`  out  1  coefficient write strobe.
- `section_index`  out  $clog2(NUM_SECTIONS)  target section.
- `coeff_sel`  out  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- `coeff_value`  out  COEF_WIDTH  signed coefficient.
- `busy`  out  1  high from sync byte accept until frame completion or abort.
- `done`  out  1  one-cycle pulse after a successful write burst.
- `err`  out  1  one-cycle pulse on a rejected frame.
- `err_code`  out  2  valid with `err`; 1=checksum, 2=bad section, 3=timeout; holds its last value otherwise.

## Operation
- Frame of 13 bytes: 0xA5 sync; section byte; ten coefficient bytes (b0,b1,b2,a1,a2, each MSB first); checksum = XOR of bytes 1..11.
- FSM states: IDLE, SECT, COEF, CHK, WRITE.
- IDLE: `s_ready`=1. 0xA5 -> SECT, `busy`=1. Any other byte is discarded silently.
- SECT: stores the byte and sets a bad-section flag if the value is >= NUM_SECTIONS. An out-of-range section is not aborted here; the frame is consumed in full. -> COEF.
- COEF: a byte counter 0..9 assembles the five coefficients into staging registers. After the 10th byte -> CHK.
- CHK: on accept, compare against the running XOR.
  - Bad section -> `err`, code 2, IDLE. Bad section takes priority over a checksum error.
  - Checksum mismatch -> `err`, code 1, IDLE.
  - Otherwise -> WRITE.
- WRITE: `s_ready`=0. Five consecutive cycles of `coeff_wr_en`=1, with `coeff_sel` 0..4 and matching `coeff_value`; `section_index` is held. Then `done`, IDLE.
- A rejected frame issues no writes. Staging registers are never written to the filter partially, except on reset during WRITE.
- Timeout: a counter runs in SECT/COEF/CHK on every cycle without a transfer and clears on each transfer. When it reaches TIMEOUT -> `err`, code 3, IDLE. A byte presented in that same cycle is not accepted (`s_ready` is 0 in the timeout cycle).
- A 0xA5 byte inside a frame is data, not resync.

## Timing
- All outputs are registered.
- Reset values:
  - `s_ready`=0 while `rst` is asserted, 1 in the first cycle after release.
  - `coeff_wr_en`, `busy`, `done`, `err` = 0.
  - `err_code`, `section_index`, `coeff_sel`, `coeff_value` = 0.
  - FSM in IDLE; counters and XOR cleared.
- Checksum byte accepted at edge E0 (good frame):
  - `coeff_wr_en`=1 in the cycles after E0..E4, with `coeff_sel`=0..4.
  - After E5: `coeff_wr_en`=0, `done`=1, `busy`=0, `s_ready`=1.
  - `s_ready`=0 in the cycles after E0..E4.
- Rejected frame: after E0, `err`=1 and `busy`=0; `s_ready` stays 1. Write latency = 1 cycle; burst = 5 cycles; frame-to-done minimum = 13 transfer cycles + 6.
- Back-to-back frames: a sync byte may be accepted in the `done`/`err` cycle.
- `s_valid` may drop at any time. `s_data` is only sampled on a transfer.
- `rst` during WRITE: `coeff_wr_en`=0 from the cycle after the reset edge, and the remaining writes are dropped. Earlier writes stand (section partially programmed; host must resend).

## Test plan
- Good frame: A5 01 40 00 20 00 10 00 C0 00 08 00 + checksum 0x01^0x40^0x20^0x10^0xC0^0x08=0xB9.
  - Response: five writes to section 1, values 0x4000, 0x2000, 0x1000, 0xC000, 0x0800 with `coeff_sel` 0..4 on consecutive cycles, then a `done` pulse.
  - `s_ready` low exactly 5 cycles.
- Same frame with checksum 0xB8 -> `err`=1, `err_code`=1, no `coeff_wr_en`. Section byte 0x02 (NUM_SECTIONS=2) with otherwise valid checksum -> `err_code`=2, no writes.
- Garbage 00 FF 5A before a good frame -> garbage ignored, `busy` stays 0 until A5, frame programs normally.
- TIMEOUT=16: stall `s_valid` 16 cycles after the 5th coefficient byte -> `err_code`=3, IDLE. A following good frame succeeds.
- Random `s_valid` gaps (<TIMEOUT) across a good frame -> identical write burst. Assert `rst` during the third write cycle -> exactly 3 writes seen, all outputs at reset values next cycle, `s_ready`=1 the cycle after release.
